// File: rtl/prim_sync_reqack_arb.sv
// Round-robin arbiter in front of a 4-phase req/ack handshake into a remote
// clock domain. One requester is served per handshake; ack_i is brought in
// through a two-flop synchronizer. A sticky flag records handshakes that run
// longer than TimeoutCycles; such handshakes still run to completion.
module prim_sync_reqack_arb #(
   parameter int NumReq        = 4,
   parameter int Width         = 16,
   parameter int TimeoutCycles = 1024
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [NumReq-1:0]         req_i,
   input  logic [NumReq*Width-1:0]   data_i,
   output logic [NumReq-1:0]         done_o,
   output logic                      req_o,
   output logic [Width-1:0]          data_o,
   input  logic                      ack_i,
   output logic [$clog2(NumReq)-1:0] gnt_idx_o,
   output logic                      busy_o,
   output logic                      timeout_o,
   input  logic                      clr_timeout_i
);

   localparam int IdxW = $clog2(NumReq);
   localparam int CntW = $clog2(TimeoutCycles + 1);
   localparam logic [CntW-1:0] CntMax  = CntW'(TimeoutCycles);
   localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NumReq - 1);
   localparam logic [NumReq-1:0] OneHot0 = NumReq'(1);

   typedef enum logic [1:0] {
      StIdle,
      StReqHi,
      StReqLo,
      StDone
   } state_e;

   state_e          state;
   logic            ack_sync_p0;
   logic            ack_sync_p1;
   logic [IdxW-1:0] last_gnt;
   logic [CntW-1:0] hs_cnt;
   logic [IdxW-1:0] win_idx;
   logic            win_vld;
   logic            hs_active;
   int              cand;

   // Two-flop synchronizer; ack_sync_p1 is the only view of ack_i in the design
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ack_sync_p0 <= 1'b0;
         ack_sync_p1 <= 1'b0;
      end else begin
         ack_sync_p0 <= ack_i;
         ack_sync_p1 <= ack_sync_p0;
      end
   end

   // Round-robin winner: first set request at or above last_gnt+1, wrapping.
   // Walking the offsets downward lets the smallest offset overwrite last.
   always_comb begin
      win_idx = last_gnt;
      win_vld = 1'b0;
      cand    = 0;
      for (int i = NumReq; i >= 1; i--) begin
         cand = int'(last_gnt) + i;
         if (cand >= NumReq) begin
            cand = cand - NumReq;
         end
         if (req_i[cand]) begin
            win_idx = IdxW'(cand);
            win_vld = 1'b1;
         end
      end
   end

   assign hs_active = (state == StReqHi) || (state == StReqLo);

   // Handshake FSM with registered outputs, duration counter and timeout flag
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= StIdle;
         req_o     <= 1'b0;
         data_o    <= '0;
         gnt_idx_o <= '0;
         done_o    <= '0;
         busy_o    <= 1'b0;
         timeout_o <= 1'b0;
         hs_cnt    <= '0;
         last_gnt  <= LastIdx;
      end else begin
         done_o <= '0;

         if (hs_active && (hs_cnt != CntMax)) begin
            hs_cnt <= hs_cnt + 1'b1;
         end

         // Set takes priority over a coincident clear
         if (hs_active && (hs_cnt == CntLast)) begin
            timeout_o <= 1'b1;
         end else if (clr_timeout_i) begin
            timeout_o <= 1'b0;
         end

         unique case (state)
            StIdle: begin
               if (win_vld) begin
                  state     <= StReqHi;
                  req_o     <= 1'b1;
                  busy_o    <= 1'b1;
                  data_o    <= data_i[win_idx*Width +: Width];
                  gnt_idx_o <= win_idx;
                  last_gnt  <= win_idx;
                  hs_cnt    <= '0;
               end
            end
            StReqHi: begin
               if (ack_sync_p1) begin
                  state <= StReqLo;
                  req_o <= 1'b0;
               end
            end
            StReqLo: begin
               if (!ack_sync_p1) begin
                  state  <= StDone;
                  done_o <= OneHot0 << gnt_idx_o;
               end
            end
            StDone: begin
               state  <= StIdle;
               busy_o <= 1'b0;
            end
            default: begin
               state  <= StIdle;
               req_o  <= 1'b0;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prim_sync_reqack_arb.sv
// Directed bench for prim_sync_reqack_arb: a behavioural remote side answers
// req_o with a programmable delay, and hand-computed values are compared.
module tb_prim_sync_reqack_arb;

   localparam int NumReq        = 4;
   localparam int Width         = 16;
   localparam int TimeoutCycles = 8;

   logic                      clk_i = 1'b0;
   logic                      rst_i;
   logic [NumReq-1:0]         req_i;
   logic [NumReq*Width-1:0]   data_i;
   logic [NumReq-1:0]         done_o;
   logic                      req_o;
   logic [Width-1:0]          data_o;
   logic                      ack_i;
   logic [$clog2(NumReq)-1:0] gnt_idx_o;
   logic                      busy_o;
   logic                      timeout_o;
   logic                      clr_timeout_i;

   int   n_chk   = 0;
   int   n_fail  = 0;
   int   n_done  = 0;
   logic rem_en  = 1'b0;
   int   rem_dly = 0;
   int   rem_cnt = 0;
   logic rem_ack = 1'b0;
   logic ack_glitch = 1'b0;

   assign ack_i = rem_ack | ack_glitch;

   prim_sync_reqack_arb #(
      .NumReq        (NumReq),
      .Width         (Width),
      .TimeoutCycles (TimeoutCycles)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .req_i         (req_i),
      .data_i        (data_i),
      .done_o        (done_o),
      .req_o         (req_o),
      .data_o        (data_o),
      .ack_i         (ack_i),
      .gnt_idx_o     (gnt_idx_o),
      .busy_o        (busy_o),
      .timeout_o     (timeout_o),
      .clr_timeout_i (clr_timeout_i)
   );

   always #5 clk_i = ~clk_i;

   // Remote domain: mirror req_o onto ack after rem_dly falling edges
   initial begin
      forever begin
         @(negedge clk_i);
         if (rem_en && (rem_ack != req_o)) begin
            if (rem_cnt >= rem_dly) begin
               rem_ack = req_o;
               rem_cnt = 0;
            end else begin
               rem_cnt = rem_cnt + 1;
            end
         end else begin
            rem_cnt = 0;
         end
      end
   end

   // Count every completion pulse seen
   always @(negedge clk_i) begin
      if (done_o != '0) n_done <= n_done + 1;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got hang expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(input string tag, output int cyc);
      logic seen;
      seen = 1'b0;
      cyc  = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk_i);
         cyc = i + 1;
         if (done_o != '0) begin
            seen = 1'b1;
            break;
         end
      end
      chk({tag, "_done_seen"}, 32'(seen), 32'd1);
   endtask

   task automatic xfer(input string tag, input logic [NumReq-1:0] req, input int exp_gnt);
      int cyc;
      req_i = req;
      wait_done(tag, cyc);
      chk({tag, "_gnt"}, 32'(gnt_idx_o), 32'(exp_gnt));
      chk({tag, "_done"}, 32'(done_o), 32'(1 << exp_gnt));
      req_i = '0;
   endtask

   initial begin
      int cyc;
      int nd;
      logic bad;
      int exp_order [5] = '{0, 1, 2, 3, 0};

      rst_i         = 1'b1;
      req_i         = '0;
      clr_timeout_i = 1'b0;
      data_i        = {16'h3333, 16'hA5A5, 16'h1111, 16'h0F0F};

      // Reset values
      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;
      chk("rst_req_o", 32'(req_o), 32'd0);
      chk("rst_data_o", 32'(data_o), 32'd0);
      chk("rst_gnt", 32'(gnt_idx_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_timeout", 32'(timeout_o), 32'd0);

      // One-cycle ack pulse while idle is ignored
      ack_glitch = 1'b1;
      @(negedge clk_i);
      ack_glitch = 1'b0;
      bad = 1'b0;
      repeat (6) begin
         @(negedge clk_i);
         if (req_o || busy_o || (done_o != '0)) bad = 1'b1;
      end
      chk("glitch_no_activity", 32'(bad), 32'd0);

      // Fairness with all requests held, immediate remote ack
      rem_en  = 1'b1;
      rem_dly = 0;
      req_i   = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         wait_done($sformatf("fair%0d", g), cyc);
         if (g == 0) chk("fair0_latency", 32'(cyc), 32'd7);
         chk($sformatf("fair%0d_gnt", g), 32'(gnt_idx_o), 32'(exp_order[g]));
         chk($sformatf("fair%0d_done", g), 32'(done_o), 32'(1 << exp_order[g]));
         chk($sformatf("fair%0d_data", g), 32'(data_o), 32'(data_i[exp_order[g]*Width +: Width]));
      end
      req_i = '0;
      repeat (3) @(negedge clk_i);
      chk("fair_done_count", 32'(n_done), 32'd5);

      // Single transfer, remote answers 3 cycles after each req_o edge
      rem_dly = 3;
      nd = n_done;
      req_i = 4'b0100;
      @(negedge clk_i);
      chk("single_req_hi", 32'(req_o), 32'd1);
      chk("single_busy_hi", 32'(busy_o), 32'd1);
      chk("single_data", 32'(data_o), 32'hA5A5);
      chk("single_gnt", 32'(gnt_idx_o), 32'd2);
      wait_done("single", cyc);
      chk("single_done", 32'(done_o), 32'b0100);
      req_i = '0;
      @(negedge clk_i);
      chk("single_done_clear", 32'(done_o), 32'd0);
      chk("single_busy_lo", 32'(busy_o), 32'd0);
      chk("single_req_lo", 32'(req_o), 32'd0);
      chk("single_data_held", 32'(data_o), 32'hA5A5);
      repeat (2) @(negedge clk_i);
      chk("single_one_pulse", 32'(n_done - nd), 32'd1);
      clr_timeout_i = 1'b1;
      @(negedge clk_i);
      clr_timeout_i = 1'b0;

      // Wrap-around: reach last_gnt=3, then 1001 grants 0 then 3
      rem_dly = 0;
      xfer("wrap_setup", 4'b1000, 3);
      @(negedge clk_i);
      xfer("wrap_a", 4'b1001, 0);
      @(negedge clk_i);
      xfer("wrap_b", 4'b1001, 3);
      @(negedge clk_i);

      // Timeout: ack withheld, flag sets after 8 handshake cycles
      rem_en = 1'b0;
      chk("to_clear_before", 32'(timeout_o), 32'd0);
      req_i = 4'b0010;
      @(negedge clk_i);
      chk("to_req_hi", 32'(req_o), 32'd1);
      repeat (7) @(negedge clk_i);
      chk("to_not_yet", 32'(timeout_o), 32'd0);
      @(negedge clk_i);
      chk("to_set", 32'(timeout_o), 32'd1);
      req_i = 4'b0011;
      repeat (11) @(negedge clk_i);
      chk("to_req_still_hi", 32'(req_o), 32'd1);
      chk("to_gnt_stable", 32'(gnt_idx_o), 32'd1);
      chk("to_data_stable", 32'(data_o), 32'h1111);
      rem_en = 1'b1;
      wait_done("to", cyc);
      chk("to_done", 32'(done_o), 32'b0010);
      req_i = '0;
      chk("to_sticky", 32'(timeout_o), 32'd1);
      clr_timeout_i = 1'b1;
      @(negedge clk_i);
      clr_timeout_i = 1'b0;
      chk("to_cleared", 32'(timeout_o), 32'd0);
      repeat (2) @(negedge clk_i);

      // Reset during REQ_HI abandons the transfer
      rem_en = 1'b0;
      req_i  = 4'b0100;
      @(negedge clk_i);
      chk("rhi_req_hi", 32'(req_o), 32'd1);
      repeat (2) @(negedge clk_i);
      rst_i = 1'b1;
      req_i = '0;
      @(negedge clk_i);
      rst_i = 1'b0;
      chk("rhi_req_lo", 32'(req_o), 32'd0);
      chk("rhi_busy", 32'(busy_o), 32'd0);
      chk("rhi_gnt", 32'(gnt_idx_o), 32'd0);
      nd = n_done;
      repeat (10) @(negedge clk_i);
      chk("rhi_no_done", 32'(n_done - nd), 32'd0);
      rem_en  = 1'b1;
      rem_dly = 0;
      xfer("rhi_next", 4'b1111, 0);
      repeat (3) @(negedge clk_i);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
